// File: rtl/ps2_host_tx.sv
// ==========================================================================
// ps2_host_tx : PS/2 host-to-device command byte transmitter (optional timers: PS2_TX_TIMEOUT_EN)
// Revision: 1.0
// ==========================================================================
`default_nettype none

module ps2_host_tx #(
  parameter int INHIBIT_CYCLES       = 1000,
  parameter int START_TIMEOUT_CYCLES = 150000,
  parameter int XFER_TIMEOUT_CYCLES  = 20000,
  parameter int SYNC_STAGES          = 2
) (
  input  logic       busclk,
  input  logic       rst,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  output logic       clk_out,
  output logic       data_out,
  input  logic       tx_valid,
  input  logic [7:0] tx_data,
  output logic       tx_ready,
  output logic       tx_busy,
  output logic       tx_done,
  output logic       ack_error,
  output logic       timeout_error
);

  localparam int CNT_MAX_A = (INHIBIT_CYCLES > START_TIMEOUT_CYCLES) ? INHIBIT_CYCLES : START_TIMEOUT_CYCLES;
  localparam int CNT_MAX   = (CNT_MAX_A > XFER_TIMEOUT_CYCLES) ? CNT_MAX_A : XFER_TIMEOUT_CYCLES;
  localparam int CNT_W     = $clog2(CNT_MAX + 1);
  localparam logic [CNT_W-1:0] INH_LAST = CNT_W'(INHIBIT_CYCLES - 1);
`ifdef PS2_TX_TIMEOUT_EN
  localparam logic [CNT_W-1:0] START_LAST = CNT_W'(START_TIMEOUT_CYCLES - 1);
  localparam logic [CNT_W-1:0] XFER_LAST  = CNT_W'(XFER_TIMEOUT_CYCLES - 1);
`endif

  typedef enum logic [2:0] {
    S_IDLE, S_INHIBIT, S_RTS, S_SHIFT, S_ACK, S_WAIT_IDLE
  } state_t;

  state_t                 state, state_n;
  logic [SYNC_STAGES-1:0] clk_sync, data_sync;
  logic                   clk_prev, clk_s, data_s, fall;
  logic [CNT_W-1:0]       cnt, cnt_n, cnt_inc;
  logic [3:0]             bit_cnt, bit_cnt_n;
  logic [7:0]             byte_r, byte_n;
  logic                   par_r, par_n;
  logic                   data_n, done_n, ack_n;

  always_ff @(posedge busclk or posedge rst) begin
    if (rst) begin
      clk_sync  <= '1;
      data_sync <= '1;
      clk_prev  <= 1'b1;
    end else begin
      clk_sync  <= {clk_sync[SYNC_STAGES-2:0], ps2_clk};
      data_sync <= {data_sync[SYNC_STAGES-2:0], ps2_data};
      clk_prev  <= clk_sync[SYNC_STAGES-1];
    end
  end

  assign clk_s   = clk_sync[SYNC_STAGES-1];
  assign data_s  = data_sync[SYNC_STAGES-1];
  assign fall    = clk_prev & ~clk_s;
  assign cnt_inc = (cnt == {CNT_W{1'b1}}) ? cnt : cnt + CNT_W'(1);

`ifdef PS2_TX_TIMEOUT_EN
  logic timeout_n, expire;
`endif

  always_comb begin
    state_n   = state;
    cnt_n     = cnt;
    bit_cnt_n = bit_cnt;
    byte_n    = byte_r;
    par_n     = par_r;
    data_n    = data_out;
    done_n    = 1'b0;
    ack_n     = ack_error;
`ifdef PS2_TX_TIMEOUT_EN
    timeout_n = timeout_error;
    expire    = 1'b0;
`endif
    case (state)
      S_IDLE: begin
        data_n = 1'b1;
        if (tx_valid) begin
          byte_n  = tx_data;
          par_n   = ~^tx_data;
          ack_n   = 1'b0;
`ifdef PS2_TX_TIMEOUT_EN
          timeout_n = 1'b0;
`endif
          cnt_n   = '0;
          state_n = S_INHIBIT;
        end
      end
      S_INHIBIT: begin
        if (cnt == INH_LAST) begin
          data_n  = 1'b0;
          state_n = S_RTS;
        end else begin
          cnt_n = cnt_inc;
        end
      end
      S_RTS: begin
        bit_cnt_n = '0;
        cnt_n     = '0;
        state_n   = S_SHIFT;
      end
      S_SHIFT: begin
        if (fall) begin
          bit_cnt_n = bit_cnt + 4'd1;
          if (bit_cnt < 4'd8)       data_n = byte_r[bit_cnt[2:0]];
          else if (bit_cnt == 4'd8) data_n = par_r;
          else begin
            data_n  = 1'b1;
            state_n = S_ACK;
          end
        end
`ifdef PS2_TX_TIMEOUT_EN
        // One counter serves both timers: it restarts at the first falling edge.
        if (fall && bit_cnt == 4'd0)                                 cnt_n  = '0;
        else if (cnt == ((bit_cnt == 4'd0) ? START_LAST : XFER_LAST)) expire = 1'b1;
        else                                                          cnt_n  = cnt_inc;
`endif
      end
      S_ACK: begin
        if (fall) begin
          ack_n   = data_s;
          state_n = S_WAIT_IDLE;
        end
`ifdef PS2_TX_TIMEOUT_EN
        if (cnt == XFER_LAST) expire = 1'b1;
        else                  cnt_n  = cnt_inc;
`endif
      end
      S_WAIT_IDLE: begin
        if (clk_s && data_s) begin
          done_n  = 1'b1;
          state_n = S_IDLE;
        end
      end
      default: state_n = S_IDLE;
    endcase
`ifdef PS2_TX_TIMEOUT_EN
    if (expire) begin
      state_n   = S_IDLE;
      data_n    = 1'b1;
      done_n    = 1'b1;
      ack_n     = ack_error;
      timeout_n = 1'b1;
    end
`endif
  end

  always_ff @(posedge busclk or posedge rst) begin
    if (rst) begin
      state     <= S_IDLE;
      cnt       <= '0;
      bit_cnt   <= '0;
      byte_r    <= '0;
      par_r     <= 1'b0;
      clk_out   <= 1'b1;
      data_out  <= 1'b1;
      tx_ready  <= 1'b1;
      tx_busy   <= 1'b0;
      tx_done   <= 1'b0;
      ack_error <= 1'b0;
    end else begin
      state     <= state_n;
      cnt       <= cnt_n;
      bit_cnt   <= bit_cnt_n;
      byte_r    <= byte_n;
      par_r     <= par_n;
      clk_out   <= !(state_n == S_INHIBIT || state_n == S_RTS);
      data_out  <= data_n;
      tx_ready  <= (state_n == S_IDLE);
      tx_busy   <= (state_n != S_IDLE);
      tx_done   <= done_n;
      ack_error <= ack_n;
    end
  end

`ifdef PS2_TX_TIMEOUT_EN
  always_ff @(posedge busclk or posedge rst) begin
    if (rst) timeout_error <= 1'b0;
    else     timeout_error <= timeout_n;
  end
`else
  assign timeout_error = 1'b0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_ps2_host_tx.sv
// ==========================================================================
// tb_ps2_host_tx : randomized bench with a PS/2 device model and frame reference model
// Revision: 1.0
// ==========================================================================
`default_nettype none

module tb_ps2_host_tx;
  localparam int INH      = 1000;
  localparam int START_TO = 3000;
  localparam int XFER_TO  = 20000;

  logic       busclk   = 1'b0;
  logic       rst      = 1'b1;
  logic       dev_clk  = 1'b1;
  logic       dev_data = 1'b1;
  logic       tx_valid = 1'b0;
  logic [7:0] tx_data  = 8'h00;
  logic       clk_out, data_out, tx_ready, tx_busy, tx_done, ack_error, timeout_error;
  logic       line_clk, line_data;

  int checks = 0;
  int errors = 0;

  // Open-drain wiring: either side may pull a line low.
  assign line_clk  = clk_out & dev_clk;
  assign line_data = data_out & dev_data;

  always #5 busclk = ~busclk;

  ps2_host_tx #(
    .INHIBIT_CYCLES      (INH),
    .START_TIMEOUT_CYCLES(START_TO),
    .XFER_TIMEOUT_CYCLES (XFER_TO),
    .SYNC_STAGES         (2)
  ) dut (
    .busclk       (busclk),
    .rst          (rst),
    .ps2_clk      (line_clk),
    .ps2_data     (line_data),
    .clk_out      (clk_out),
    .data_out     (data_out),
    .tx_valid     (tx_valid),
    .tx_data      (tx_data),
    .tx_ready     (tx_ready),
    .tx_busy      (tx_busy),
    .tx_done      (tx_done),
    .ack_error    (ack_error),
    .timeout_error(timeout_error)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Reference frame: 8 data bits LSB first, odd parity, stop bit.
  function automatic logic [9:0] model_frame(input logic [7:0] b);
    int ones = 0;
    for (int i = 0; i < 8; i++) ones += int'(b[i]);
    return {1'b1, (ones % 2 == 0), b};
  endfunction

  always @(negedge busclk) begin
    if (!rst) begin
      checks++;
      if (tx_ready === tx_busy || (tx_done && !tx_ready) || (!tx_busy && !(clk_out && data_out))) begin
        errors++;
        $display("FAIL cycle_invariant ready=%b busy=%b done=%b clk_out=%b data_out=%b required ready=~busy, done->ready, idle lines released",
                 tx_ready, tx_busy, tx_done, clk_out, data_out);
      end
    end
  end

  task automatic start_phase(input logic [7:0] b);
    int inh, rts;
    @(negedge busclk);
    check("ready_before_accept", tx_ready, 1);
    tx_valid = 1'b1;
    tx_data  = b;
    @(negedge busclk);
    tx_valid = 1'b0;
    tx_data  = 8'($urandom);
    check("errors_cleared_on_accept", {ack_error, timeout_error}, 2'b00);
    inh = 0;
    while (clk_out == 1'b0 && data_out == 1'b1 && inh < 5000) begin
      inh++;
      @(negedge busclk);
    end
    rts = 0;
    while (clk_out == 1'b0 && data_out == 1'b0 && rts < 10) begin
      rts++;
      @(negedge busclk);
    end
    check("inhibit_len", inh, INH);
    check("rts_len", rts, 1);
    check("shift_entry_lines", {clk_out, data_out, tx_busy}, 3'b101);
  endtask

  // mode 0: normal, 1: tx_valid poke during shift, 2: reset after fall 4
  task automatic send(input logic [7:0] b, input bit nack, input int half, input int dly, input int mode);
    logic [9:0] got;
    int n;
    start_phase(b);
    repeat (dly) @(negedge busclk);
    got = '0;
    for (int k = 0; k < 10; k++) begin
      dev_clk = 1'b0;
      repeat (half) @(negedge busclk);
      dev_clk = 1'b1;
      got[k]  = line_data;
      if (mode == 2 && k == 3) begin
        check("pre_abort_data", data_out, b[3]);
        rst = 1'b1;
        #1;
        check("abort_lines_released", {clk_out, data_out}, 2'b11);
        check("abort_not_busy", {tx_busy, tx_ready}, 2'b01);
        @(negedge busclk);
        rst = 1'b0;
        return;
      end
      if (mode == 1 && k == 4) begin
        tx_valid = 1'b1;
        tx_data  = 8'h5A;
        check("ready_low_in_shift", tx_ready, 0);
        @(negedge busclk);
        tx_valid = 1'b0;
      end
      repeat (half) @(negedge busclk);
    end
    dev_data = nack;
    repeat (half) @(negedge busclk);
    dev_clk = 1'b0;
    repeat (half) @(negedge busclk);
    dev_clk  = 1'b1;
    dev_data = 1'b1;
    check("frame_bits", got, model_frame(b));
    check("device_decoded_byte", got[7:0], b);
    check("device_parity_odd", ^got[8:0], 1);
    n = 0;
    while (!tx_done && n < 200) begin
      n++;
      @(negedge busclk);
    end
    check("done_seen", tx_done, 1);
    check("ack_error", ack_error, nack);
    check("timeout_error_clear", timeout_error, 0);
    @(negedge busclk);
    check("done_one_cycle", tx_done, 0);
    check("ready_after_done", tx_ready, 1);
    if (mode == 1) begin
      repeat (30) @(negedge busclk);
      check("poke_not_queued", {tx_busy, clk_out, data_out}, 3'b011);
    end
  endtask

  task automatic silent_device();
    int n;
    start_phase(8'hF0);
`ifdef PS2_TX_TIMEOUT_EN
    n = 0;
    while (!tx_done && n < 2 * START_TO) begin
      n++;
      @(negedge busclk);
    end
    check("start_timeout_len", n, START_TO);
    check("timeout_flags", {tx_done, timeout_error, ack_error}, 3'b110);
    check("timeout_lines_released", {clk_out, data_out, tx_busy}, 3'b110);
`else
    n = 0;
    repeat (2 * START_TO) begin
      n++;
      @(negedge busclk);
      if (tx_done) break;
    end
    check("silent_no_done", n, 2 * START_TO);
    check("silent_still_shift", {tx_busy, clk_out, data_out, timeout_error}, 4'b1100);
`endif
    @(negedge busclk);
    rst = 1'b1;
    @(negedge busclk);
    rst = 1'b0;
  endtask

  initial begin
    #2ms;
    $display("FAIL watchdog simulation time limit reached");
    $display("CHECKS %0d ERRORS %0d", checks, errors + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(negedge busclk);
    check("reset_state", {clk_out, data_out, tx_ready, tx_busy, tx_done, ack_error, timeout_error}, 7'b1110000);
    rst = 1'b0;

    check("model_frame_ED", model_frame(8'hED), 10'b11_1110_1101);
    check("model_frame_F4", model_frame(8'hF4), 10'b10_1111_0100);
    check("model_parity_00", model_frame(8'h00), 10'b11_0000_0000);
    check("model_parity_01", model_frame(8'h01), 10'b10_0000_0001);

    send(8'hED, 1'b0, 12, 20, 0);
    send(8'hF4, 1'b0, 10, 5, 0);
    send(8'h00, 1'b0, 15, 30, 0);
    send(8'h3C, 1'b1, 11, 8, 0);
    send(8'hA5, 1'b0, 13, 3, 0);
    send(8'hFF, 1'b0, 15, 10, 1);
    send(8'h00, 1'b0, 12, 10, 2);
    send(8'h01, 1'b0, 12, 10, 0);

    for (int i = 0; i < 6; i++) begin
      send(8'($urandom), ($urandom_range(0, 3) == 0), $urandom_range(10, 20), $urandom_range(1, 40), 0);
    end

    silent_device();
    @(negedge busclk);
    check("reset_state_after_silent", {clk_out, data_out, tx_ready, tx_busy, tx_done, ack_error, timeout_error}, 7'b1110000);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
